// File: rtl/ram_dma_pkg.sv
// Shared types and constants for the RAM DMA engine.
package ram_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_FILL = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  localparam int WORD_STRIDE = 4;

endpackage

// File: rtl/ram_dma_engine_if.sv
// Port B bus of the simulation dual-port RAM, as seen by the DMA engine (master).
interface ram_dma_engine_if #(
  parameter int ADDR_WIDTH = 20
);
  logic                  ram_en_o;
  logic [ADDR_WIDTH-1:0] ram_addr_o;
  logic                  ram_we_o;
  logic [3:0]            ram_be_o;
  logic [31:0]           ram_wdata_o;
  logic [31:0]           ram_rdata_i;

  // No valid/ready: every access with ram_en_o=1 is taken by the RAM in that
  // cycle, and read data appears on ram_rdata_i in the following cycle.
  modport master (
    output ram_en_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o,
    input  ram_rdata_i
  );

  modport slave (
    input  ram_en_o, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o,
    output ram_rdata_i
  );
endinterface

// File: rtl/ram_dma_engine.sv
// Word copy / constant fill engine driving RAM port B, one access per cycle.
module ram_dma_engine
  import ram_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic [ADDR_WIDTH-1:0] src_addr_i,
  input  logic [ADDR_WIDTH-1:0] dst_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic [31:0]           pattern_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  aborted_o,
  output state_e                dbg_state_o,
  ram_dma_engine_if.master      ram
);

  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(WORD_STRIDE);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [31:0]           pattern_q, pattern_d;
  logic                  err_q, err_d;
  logic                  aborted_q, aborted_d;
  logic                  misaligned;
  logic                  last_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
      pattern_q <= '0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      cnt_q     <= cnt_d;
      pattern_q <= pattern_d;
      err_q     <= err_d;
      aborted_q <= aborted_d;
    end
  end

  assign last_word = (cnt_q == LEN_WIDTH'(1));

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    cnt_d      = cnt_q;
    pattern_d  = pattern_q;
    err_d      = err_q;
    aborted_d  = aborted_q;
    misaligned = (dst_addr_i[1:0] != 2'b00) ||
                 ((mode_i == MODE_COPY) && (src_addr_i[1:0] != 2'b00));
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          src_d     = src_addr_i;
          dst_d     = dst_addr_i;
          cnt_d     = len_i;
          pattern_d = pattern_i;
          err_d     = misaligned;
          aborted_d = 1'b0;
          if (misaligned || (len_i == '0)) state_d = ST_DONE;
          else if (mode_i == MODE_FILL)     state_d = ST_FILL;
          else                              state_d = ST_RD;
        end
      end
      ST_RD: begin
        // An aborted read is simply dropped; nothing has been written for it.
        if (abort_i) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          state_d = ST_WR;
        end
      end
      ST_WR, ST_FILL: begin
        src_d = src_q + STRIDE;
        dst_d = dst_q + STRIDE;
        cnt_d = cnt_q - LEN_WIDTH'(1);
        if (abort_i) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else if (last_word) begin
          state_d = ST_DONE;
        end else begin
          state_d = (state_q == ST_WR) ? ST_RD : ST_FILL;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ram.ram_en_o    = 1'b0;
    ram.ram_we_o    = 1'b0;
    ram.ram_be_o    = 4'h0;
    ram.ram_addr_o  = '0;
    ram.ram_wdata_o = '0;
    case (state_q)
      ST_RD: begin
        ram.ram_en_o   = 1'b1;
        ram.ram_addr_o = src_q;
      end
      ST_WR: begin
        // Read data from the preceding RD cycle goes straight back out.
        ram.ram_en_o    = 1'b1;
        ram.ram_we_o    = 1'b1;
        ram.ram_be_o    = 4'hF;
        ram.ram_addr_o  = dst_q;
        ram.ram_wdata_o = ram.ram_rdata_i;
      end
      ST_FILL: begin
        ram.ram_en_o    = 1'b1;
        ram.ram_we_o    = 1'b1;
        ram.ram_be_o    = 4'hF;
        ram.ram_addr_o  = dst_q;
        ram.ram_wdata_o = pattern_q;
      end
      default: ;
    endcase
  end

  assign busy_o      = (state_q == ST_RD) || (state_q == ST_WR) || (state_q == ST_FILL);
  assign done_o      = (state_q == ST_DONE);
  assign err_o       = done_o && err_q;
  assign aborted_o   = done_o && aborted_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ram_dma_engine.sv
// Self-checking bench for ram_dma_engine with a behavioural RAM and transfer model.
module tb_ram_dma_engine;
  import ram_dma_pkg::*;

  localparam int AW     = 10;
  localparam int LW     = 16;
  localparam int NWORDS = 1 << (AW - 2);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i, mode_i, abort_i;
  logic [AW-1:0] src_addr_i, dst_addr_i;
  logic [LW-1:0] len_i;
  logic [31:0]   pattern_i;
  logic          busy_o, done_o, err_o, aborted_o;
  state_e        dbg_state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_dma_engine_if #(.ADDR_WIDTH(AW)) bus ();

  ram_dma_engine #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .mode_i     (mode_i),
    .src_addr_i (src_addr_i),
    .dst_addr_i (dst_addr_i),
    .len_i      (len_i),
    .pattern_i  (pattern_i),
    .abort_i    (abort_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .aborted_o  (aborted_o),
    .dbg_state_o(dbg_state),
    .ram        (bus.master)
  );

  // Synchronous RAM, port B: read data registered, valid the next cycle
  logic [31:0] mem     [NWORDS];
  logic [31:0] exp_mem [NWORDS];
  logic [31:0] rd_q;

  always @(posedge clk) begin
    if (bus.ram_en_o) begin
      if (bus.ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.ram_be_o[b]) mem[bus.ram_addr_o[AW-1:2]][8*b +: 8] <= bus.ram_wdata_o[8*b +: 8];
      end else begin
        rd_q <= mem[bus.ram_addr_o[AW-1:2]];
      end
    end
  end
  assign bus.ram_rdata_i = rd_q;

  // Bus monitor
  int            acc_cnt, busy_cnt, bus_bad;
  logic [AW-1:0] act_q[$];
  logic [AW-1:0] exp_q[$];

  always @(negedge clk) begin
    if (busy_o) busy_cnt++;
    if (bus.ram_en_o) begin
      acc_cnt++;
      if (bus.ram_addr_o[1:0] != 2'b00) bus_bad++;
      if (bus.ram_we_o) begin
        act_q.push_back(bus.ram_addr_o);
        if (bus.ram_be_o !== 4'hF) bus_bad++;
      end else if (bus.ram_be_o !== 4'h0) begin
        bus_bad++;
      end
    end
  end

  task automatic init_mem();
    for (int i = 0; i < NWORDS; i++) begin
      logic [31:0] w;
      w          = $urandom;
      mem[i]     = w;
      exp_mem[i] = w;
    end
  endtask

  task automatic run_xfer(input logic md, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                          input int len, input logic [31:0] pat, input int abort_cyc,
                          input string name);
    int   exp_done, exp_acc, written, cyc, diffs;
    logic exp_err, exp_ab;
    logic got_err, got_ab, got_busy;
    // Reference: transfer outcome from the operation rules, then word-by-word copy in ascending order
    exp_err = (dst[1:0] != 2'b00) || (md == MODE_COPY && src[1:0] != 2'b00);
    exp_ab  = 1'b0;
    exp_q.delete();
    if (exp_err || len == 0) begin
      written = 0; exp_acc = 0; exp_done = 1;
    end else if (md == MODE_COPY) begin
      written = len; exp_acc = 2 * len; exp_done = 2 * len + 1;
      if (abort_cyc >= 1 && abort_cyc <= 2 * len) begin
        exp_ab   = 1'b1;
        exp_done = abort_cyc + 1;
        exp_acc  = abort_cyc;
        written  = abort_cyc / 2;
      end
    end else begin
      written = len; exp_acc = len; exp_done = len + 1;
      if (abort_cyc >= 1 && abort_cyc <= len) begin
        exp_ab = 1'b1; exp_done = abort_cyc + 1; exp_acc = abort_cyc; written = abort_cyc;
      end
    end
    for (int i = 0; i < written; i++) begin
      int si, di;
      si = ((int'(src) >> 2) + i) % NWORDS;
      di = ((int'(dst) >> 2) + i) % NWORDS;
      exp_mem[di] = (md == MODE_COPY) ? exp_mem[si] : pat;
      exp_q.push_back(AW'(di * 4));
    end

    @(negedge clk);
    acc_cnt = 0; busy_cnt = 0; bus_bad = 0; act_q.delete();
    start_i = 1'b1; mode_i = md; src_addr_i = src; dst_addr_i = dst;
    len_i = LW'(len); pattern_i = pat;
    @(posedge clk); #1;
    start_i = 1'b0;
    src_addr_i = AW'($urandom); dst_addr_i = AW'($urandom); pattern_i = $urandom;
    cyc = 1;
    forever begin
      abort_i = (cyc == abort_cyc);
      if (done_o === 1'b1 || cyc >= 300) break;
      @(posedge clk); #1;
      cyc++;
    end
    got_err = err_o; got_ab = aborted_o; got_busy = busy_o;
    abort_i = 1'b0;
    @(posedge clk); #1;

    checks++;
    if (cyc !== exp_done) begin
      failures++; $display("FAIL %s done_cycle: got %0d expected %0d", name, cyc, exp_done);
    end
    checks++;
    if (got_err !== exp_err || got_ab !== exp_ab || got_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s result_flags: got err=%b aborted=%b busy=%b expected err=%b aborted=%b busy=0",
               name, got_err, got_ab, got_busy, exp_err, exp_ab);
    end
    checks++;
    if (done_o !== 1'b0) begin
      failures++; $display("FAIL %s done_pulse_width: done_o got %b expected 0 one cycle later", name, done_o);
    end
    checks++;
    if (acc_cnt !== exp_acc) begin
      failures++; $display("FAIL %s access_count: got %0d expected %0d", name, acc_cnt, exp_acc);
    end
    checks++;
    if (busy_cnt !== exp_done - 1) begin
      failures++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, exp_done - 1);
    end
    checks++;
    if (bus_bad !== 0) begin
      failures++; $display("FAIL %s bus_encoding: got %0d bad be/addr accesses expected 0", name, bus_bad);
    end
    checks++;
    if (act_q != exp_q) begin
      failures++;
      $display("FAIL %s write_addresses: got %0d writes (first 0x%0h) expected %0d writes (first 0x%0h)",
               name, act_q.size(), (act_q.size() > 0) ? act_q[0] : '0,
               exp_q.size(), (exp_q.size() > 0) ? exp_q[0] : '0);
    end
    diffs = 0;
    for (int i = 0; i < NWORDS; i++) if (mem[i] !== exp_mem[i]) diffs++;
    checks++;
    if (diffs != 0) begin
      failures++; $display("FAIL %s memory_image: got %0d differing words expected 0", name, diffs);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({busy_o, done_o, err_o, aborted_o, bus.ram_en_o, bus.ram_we_o} !== 6'b0 ||
        bus.ram_addr_o !== '0 || bus.ram_be_o !== 4'h0 || bus.ram_wdata_o !== 32'h0 ||
        dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL %s outputs: got busy=%b done=%b err=%b ab=%b en=%b we=%b addr=0x%0h be=%h wdata=%h state=%0d expected all 0 / IDLE",
               name, busy_o, done_o, err_o, aborted_o, bus.ram_en_o, bus.ram_we_o,
               bus.ram_addr_o, bus.ram_be_o, bus.ram_wdata_o, dbg_state);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; mode_i = 1'b0; abort_i = 1'b0;
    src_addr_i = '0; dst_addr_i = '0; len_i = '0; pattern_i = '0;
    repeat (3) @(posedge clk);
    #1 check_idle_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1 check_idle_outputs("after_reset_release");
  endtask

  task automatic test_copy();
    init_mem();
    mem[16'h100 >> 2] = 32'h11111111; exp_mem[16'h100 >> 2] = 32'h11111111;
    mem[16'h104 >> 2] = 32'h22222222; exp_mem[16'h104 >> 2] = 32'h22222222;
    mem[16'h108 >> 2] = 32'h33333333; exp_mem[16'h108 >> 2] = 32'h33333333;
    run_xfer(MODE_COPY, 10'h100, 10'h200, 3, 32'h0, 0, "copy3");
    checks++;
    if (mem[10'h200 >> 2] !== 32'h11111111 || mem[10'h204 >> 2] !== 32'h22222222 ||
        mem[10'h208 >> 2] !== 32'h33333333) begin
      failures++;
      $display("FAIL copy3 dst_words: got %h %h %h expected 11111111 22222222 33333333",
               mem[10'h200 >> 2], mem[10'h204 >> 2], mem[10'h208 >> 2]);
    end
  endtask

  task automatic test_fill_wrap();
    init_mem();
    run_xfer(MODE_FILL, 10'h000, 10'h3FC, 4, 32'hDEADBEEF, 0, "fill_wrap");
    checks++;
    if (act_q.size() != 4 || act_q[0] !== 10'h3FC || act_q[1] !== 10'h000 ||
        act_q[2] !== 10'h004 || act_q[3] !== 10'h008) begin
      failures++;
      $display("FAIL fill_wrap wrap_order: got %0d writes first 0x%0h expected 3FC,000,004,008",
               act_q.size(), (act_q.size() > 0) ? act_q[0] : '0);
    end
  endtask

  task automatic test_misaligned();
    init_mem();
    run_xfer(MODE_COPY, 10'h102, 10'h200, 3, 32'h0, 0, "misaligned_src");
    run_xfer(MODE_FILL, 10'h102, 10'h200, 3, 32'h5A5A5A5A, 0, "fill_ignores_src");
    run_xfer(MODE_FILL, 10'h000, 10'h201, 3, 32'h5A5A5A5A, 0, "misaligned_dst");
  endtask

  task automatic test_len_zero();
    init_mem();
    run_xfer(MODE_COPY, 10'h100, 10'h200, 0, 32'h0, 0, "len0_copy");
    run_xfer(MODE_FILL, 10'h100, 10'h200, 0, 32'hFFFFFFFF, 0, "len0_fill");
  endtask

  task automatic test_abort();
    init_mem();
    run_xfer(MODE_COPY, 10'h040, 10'h180, 8, 32'h0, 5, "abort_third_rd");
    run_xfer(MODE_COPY, 10'h040, 10'h180, 8, 32'h0, 4, "abort_in_wr");
    run_xfer(MODE_FILL, 10'h040, 10'h180, 8, 32'hCAFEF00D, 3, "abort_in_fill");
  endtask

  task automatic test_async_reset();
    init_mem();
    @(negedge clk);
    start_i = 1'b1; mode_i = MODE_COPY; src_addr_i = 10'h040; dst_addr_i = 10'h080; len_i = 4;
    @(posedge clk); #1 start_i = 1'b0;
    @(posedge clk); #2;
    checks++;
    if (bus.ram_we_o !== 1'b1) begin
      failures++; $display("FAIL async_reset reach_wr: ram_we_o got %b expected 1", bus.ram_we_o);
    end
    rst_n = 1'b0;
    #1 check_idle_outputs("async_reset_mid_wr");
    @(negedge clk) rst_n = 1'b1;
    init_mem();
    run_xfer(MODE_COPY, 10'h040, 10'h080, 4, 32'h0, 0, "copy_after_reset");
  endtask

  task automatic test_back_to_back();
    init_mem();
    run_xfer(MODE_FILL, 10'h000, 10'h010, 5, 32'h12345678, 0, "b2b_fill");
    run_xfer(MODE_COPY, 10'h010, 10'h014, 5, 32'h0, 0, "b2b_overlap_copy");
  endtask

  task automatic test_random();
    init_mem();
    for (int t = 0; t < 24; t++) begin
      logic          md;
      logic [AW-1:0] s, d;
      int            len, ab;
      md  = 1'($urandom_range(0, 1));
      s   = AW'($urandom) & ~AW'(3);
      d   = AW'($urandom) & ~AW'(3);
      if ($urandom_range(0, 7) == 0) s[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) d[1:0] = 2'($urandom_range(1, 3));
      len = $urandom_range(0, 12);
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2 * len + 2) : 0;
      run_xfer(md, s, d, len, $urandom, ab, $sformatf("random_%0d", t));
    end
  endtask

  initial begin
    test_reset();
    test_copy();
    test_fill_wrap();
    test_misaligned();
    test_len_zero();
    test_abort();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_dma_engine.md
# ram_dma_engine

Bus-initiator engine that drives the byte-addressed, word-wide port B of the simulation dual-port RAM. On a start pulse it either copies a block of 32-bit words from one RAM region to another or fills a region with a constant pattern, issuing one RAM access per cycle. It sits beside the core in the Verilator testbench top and pre-loads or relocates memory images, or scrubs memory, without host-side byte writes.

## Interface
- ADDR_WIDTH, 20, RAM byte-address width; must be ≥ 3.
- LEN_WIDTH, 16, width of the word-count field.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_i  in  1  start request; sampled only in IDLE.
- mode_i  in  1  0 = copy, 1 = fill; sampled with start_i.
- src_addr_i  in  ADDR_WIDTH  copy source byte address; sampled with start_i.
- dst_addr_i  in  ADDR_WIDTH  destination byte address; sampled with start_i.
- len_i  in  LEN_WIDTH  number of 32-bit words; sampled with start_i.
- pattern_i  in  32  fill word; sampled with start_i.
- abort_i  in  1  stop request; sampled while busy.
- busy_o  out  1  transfer in progress.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  misaligned request; valid while done_o = 1.
- aborted_o  out  1  transfer cut short; valid while done_o = 1.
- ram_en_o  out  1  RAM access enable.
- ram_addr_o  out  ADDR_WIDTH  RAM byte address; bits [1:0] always 0.
- ram_we_o  out  1  1 = write, 0 = read.
- ram_be_o  out  4  byte enables; 4'hF on every write, 4'h0 on reads.
- ram_wdata_o  out  32  write data.
- ram_rdata_i  in  32  read data, valid the cycle after a read access.

## Operation
- States: IDLE, RD, WR, FILL, DONE.
- Reset: the block enters IDLE. Every output is 0.
- IDLE, start_i = 1: the block latches all request inputs.
  - src or dst has bits [1:0] ≠ 0 → DONE with err_o = 1. src is checked in copy mode only. No RAM access is issued.
  - len_i = 0 → DONE with no RAM access.
  - Otherwise copy mode → RD, fill mode → FILL.
- RD: drives en = 1, we = 0, addr = current src. Next state is WR.
- WR: drives en = 1, we = 1, addr = current dst, wdata = ram_rdata_i (pass-through). After the access:
  - src and dst each advance by 4.
  - The remaining count decrements.
  - Next state is DONE when the count reaches 0, otherwise RD.
- FILL: drives en = 1, we = 1, addr = current dst, wdata = latched pattern. dst advances by 4 and the count decrements. Next state is DONE when the count reaches 0, otherwise FILL.
- DONE: done_o = 1 for one cycle. err_o and aborted_o show the result. Next state is IDLE.
- Address arithmetic is modulo 2**ADDR_WIDTH. Wrap from the top word to 0 is legal and silent.
- Overlapping copy regions: copy proceeds word by word in ascending order. Each read sees all earlier writes, so dst > src overlap replicates data by design.
- abort_i in RD: the read completes and no write follows. Next state is DONE with aborted_o = 1.
- abort_i in WR or FILL: the current write completes. Next state is DONE with aborted_o = 1.
- abort_i in IDLE or DONE is ignored. start_i outside IDLE is ignored.
- Asynchronous reset mid-transfer forces IDLE at once, with ram_en_o = 0 and no pending write. A partially written RAM is acceptable.

## Timing
- Registered FSM. RAM outputs decode from state and datapath registers only. The one exception is ram_wdata_o in WR, which passes ram_rdata_i through combinationally.
- Start sampled on edge 0:
  - Copy of N words: the first read is in cycle 1. Writes fall in cycles 2, 4, …, 2N. done_o is high in cycle 2N+1.
  - Fill of N words: writes fall in cycles 1..N. done_o is high in cycle N+1.
  - len = 0 or err: done_o is high in cycle 1.
- busy_o = 1 exactly in RD, WR and FILL.
- A new start_i is accepted in the cycle after done_o.

## Structure
- Package ram_dma_pkg holds:
  - the state enum,
  - the mode constants MODE_COPY = 1'b0 and MODE_FILL = 1'b1,
  - the word-stride constant 4.
- Single module. No sub-module is needed; the address and count registers are inline.

## Test plan
- Copy: src 0x100, dst 0x200, len 3, RAM preloaded with 0x11111111 / 0x22222222 / 0x33333333 → those words appear at 0x200–0x20B. done_o is high in cycle 7, with 6 RAM accesses.
- Fill: dst 0x3FC, pattern 0xDEADBEEF, len 4, ADDR_WIDTH 10 → writes go to 0x3FC, 0x000, 0x004, 0x008 (wrap). done_o is high in cycle 5.
- Misaligned: src 0x102, copy → done_o and err_o are high in cycle 1. ram_en_o never asserts.
- len 0 → done_o in cycle 1, err_o = 0, no RAM access.
- Abort: copy len 8, abort_i asserted in the cycle of the third RD → that read is not written back. done_o is high the next cycle with aborted_o = 1. Exactly 2 words are written.
- Reset: rst_n low during a WR → all outputs are 0 immediately. After release the block is in IDLE and a new copy runs correctly.
